// File: rtl/ahbl_i2s_rx_fifo_pkg.sv
// Shared register map, field positions and channel-mode encodings for the
// AHB-Lite I2S receiver.
package ahbl_i2s_pkg;

    localparam logic [7:0] CTRL_OFF   = 8'h00;
    localparam logic [7:0] STATUS_OFF = 8'h04;
    localparam logic [7:0] DATA_OFF   = 8'h08;
    localparam logic [7:0] CLKDIV_OFF = 8'h0C;

    localparam logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF;

    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_MODE_LSB    = 1;
    localparam int CTRL_CLR_BIT     = 3;
    localparam int CTRL_THRESH_LSB  = 8;

    localparam int STATUS_EMPTY_BIT = 0;
    localparam int STATUS_FULL_BIT  = 1;
    localparam int STATUS_OVF_BIT   = 2;
    localparam int STATUS_LEVEL_LSB = 16;

    // MODE value 2'b11 also selects stereo.
    typedef enum logic [1:0] {
        MODE_LEFT   = 2'b00,
        MODE_RIGHT  = 2'b01,
        MODE_STEREO = 2'b10
    } mode_e;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } chan_e;

    function automatic logic mode_accepts(input logic [1:0] mode, input logic chan);
        if (mode[1])
            return 1'b1;
        return (mode == MODE_RIGHT) ? (chan == CH_RIGHT) : (chan == CH_LEFT);
    endfunction

endpackage

// File: rtl/ahbl_i2s_rx_fifo_i2s_rx_core.sv
// I2S master receive engine: SCK/WS generation, MSB-first deserialiser and
// per-slot commit with the channel of the slot just finished.
module i2s_rx_core
    import ahbl_i2s_pkg::*;
#(
    parameter int SAMPLE_W = 24
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic                en,
    input  logic [7:0]          div,
    input  logic                rx,
    output logic                i2s_clk,
    output logic                ws,
    output logic                sample_valid,
    output logic [SAMPLE_W-1:0] sample,
    output logic                chan
);

    localparam int CNT_W = $clog2(SAMPLE_W);

    logic [7:0]          presc;
    logic [7:0]          div_act;
    logic [CNT_W-1:0]    bit_cnt;
    logic [SAMPLE_W-1:0] shifter;
    logic                pend;
    logic                wrap;

    assign wrap = (presc == div_act);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            presc        <= '0;
            div_act      <= '0;
            bit_cnt      <= '0;
            shifter      <= '0;
            pend         <= 1'b0;
            i2s_clk      <= 1'b0;
            ws           <= 1'b0;
            sample_valid <= 1'b0;
            sample       <= '0;
            chan         <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (!en) begin
                presc   <= '0;
                div_act <= div;
                bit_cnt <= '0;
                shifter <= '0;
                pend    <= 1'b0;
                i2s_clk <= 1'b0;
                ws      <= 1'b0;
            end else if (wrap) begin
                presc   <= '0;
                div_act <= div;
                i2s_clk <= ~i2s_clk;
                if (!i2s_clk) begin
                    // Rising SCK: the bit after a WS change is the LSB of the
                    // slot that just ended, so that slot commits here.
                    shifter <= {shifter[SAMPLE_W-2:0], rx};
                    if (pend) begin
                        pend         <= 1'b0;
                        sample_valid <= 1'b1;
                        sample       <= {shifter[SAMPLE_W-2:0], rx};
                        chan         <= ~ws;
                    end
                end else if (bit_cnt == CNT_W'(SAMPLE_W - 1)) begin
                    bit_cnt <= '0;
                    ws      <= ~ws;
                    pend    <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else begin
                presc <= presc + 8'd1;
            end
        end
    end

endmodule

// File: rtl/ahbl_i2s_rx_fifo.sv
// AHB-Lite I2S receiver with sample FIFO, sticky overflow and level-threshold
// interrupt. Zero-wait-state slave; registers decode in the data phase.
module ahbl_i2s_rx_fifo
    import ahbl_i2s_pkg::*;
#(
    parameter int SAMPLE_W   = 24,
    parameter int FIFO_DEPTH = 16,
    parameter int CLKDIV_RST = 7
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HSEL,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    input  logic        rx,
    output logic        ws,
    output logic        i2s_clk,
    output logic        irq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [7:0]          a_addr;
    logic                a_write;
    logic                a_act;
    logic                ctrl_en;
    logic [1:0]          ctrl_mode;
    logic [LVL_W-1:0]    thresh;
    logic [7:0]          clkdiv;
    logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wptr, rptr;
    logic [LVL_W-1:0]    level;
    logic                ovf;
    logic                sample_valid;
    logic [SAMPLE_W-1:0] sample;
    logic                chan;
    logic                wr, rd, clr, push, pop, do_push, empty, full;
    logic                unused_bits;

    assign HREADYOUT   = 1'b1;
    assign unused_bits = ^{HSIZE, HADDR[31:8], HTRANS[0], HWDATA[31:CTRL_THRESH_LSB+LVL_W]};

    assign wr      = a_act & a_write;
    assign rd      = a_act & ~a_write;
    assign empty   = (level == '0);
    assign full    = (level == LVL_W'(FIFO_DEPTH));
    assign clr     = wr && (a_addr == CTRL_OFF) && HWDATA[CTRL_CLR_BIT];
    assign pop     = rd && (a_addr == DATA_OFF) && !empty;
    assign push    = sample_valid && mode_accepts(ctrl_mode, chan);
    // A pop in the same cycle frees the slot a full FIFO would otherwise lack.
    assign do_push = push && (!full || pop);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            a_addr  <= '0;
            a_write <= 1'b0;
            a_act   <= 1'b0;
        end else if (HREADY) begin
            a_addr  <= HADDR[7:0];
            a_write <= HWRITE;
            a_act   <= HSEL & HTRANS[1];
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ctrl_en   <= 1'b0;
            ctrl_mode <= MODE_LEFT;
            thresh    <= '0;
            clkdiv    <= 8'(CLKDIV_RST);
        end else if (wr) begin
            if (a_addr == CTRL_OFF) begin
                ctrl_en   <= HWDATA[CTRL_EN_BIT];
                ctrl_mode <= HWDATA[CTRL_MODE_LSB +: 2];
                thresh    <= HWDATA[CTRL_THRESH_LSB +: LVL_W];
            end else if (a_addr == CLKDIV_OFF) begin
                clkdiv <= HWDATA[7:0];
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            ovf   <= 1'b0;
        end else begin
            if (do_push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            level <= level + LVL_W'(do_push) - LVL_W'(pop);
            if (push && full && !pop)
                ovf <= 1'b1;
        end
    end

    // NOTE: the sample storage has no reset; pointers and level define which
    // entries are valid, so clearing the array would only cost logic.
    always_ff @(posedge HCLK) begin
        if (do_push && !clr)
            mem[wptr] <= sample;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET)
            irq <= 1'b0;
        else
            irq <= ((level >= thresh) && (thresh != '0)) || ovf;
    end

    // NOTE: HRDATA gets a default before the decode so no path can infer a latch.
    always_comb begin
        HRDATA = '0;
        if (rd) begin
            case (a_addr)
                CTRL_OFF: begin
                    HRDATA[CTRL_EN_BIT]                  = ctrl_en;
                    HRDATA[CTRL_MODE_LSB +: 2]           = ctrl_mode;
                    HRDATA[CTRL_THRESH_LSB +: LVL_W]     = thresh;
                end
                STATUS_OFF: begin
                    HRDATA[STATUS_EMPTY_BIT]             = empty;
                    HRDATA[STATUS_FULL_BIT]              = full;
                    HRDATA[STATUS_OVF_BIT]               = ovf;
                    HRDATA[STATUS_LEVEL_LSB +: LVL_W]    = level;
                end
                DATA_OFF: begin
                    if (!empty)
                        HRDATA = 32'($signed(mem[rptr]));
                end
                CLKDIV_OFF: HRDATA[7:0] = clkdiv;
                default:    HRDATA = UNMAPPED_DATA;
            endcase
        end
    end

    i2s_rx_core #(
        .SAMPLE_W(SAMPLE_W)
    ) u_core (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .en          (ctrl_en),
        .div         (clkdiv),
        .rx          (rx),
        .i2s_clk     (i2s_clk),
        .ws          (ws),
        .sample_valid(sample_valid),
        .sample      (sample),
        .chan        (chan)
    );

endmodule

// File: tb/tb_ahbl_i2s_rx_fifo.sv
// Directed bench for ahbl_i2s_rx_fifo: AHB read/write tasks plus an I2S
// transmitter model driving rx from the DUT's SCK/WS.
module tb_ahbl_i2s_rx_fifo;

    localparam int W = 24;
    localparam logic [31:0] A_CTRL = 32'h00, A_STATUS = 32'h04, A_DATA = 32'h08, A_CLKDIV = 32'h0C;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic [31:0] HADDR = '0;
    logic [1:0]  HTRANS = '0;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = 3'b010;
    logic [31:0] HWDATA = '0;
    logic        HSEL = 1'b0;
    logic        HREADY = 1'b1;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        rx = 1'b0;
    logic        ws;
    logic        i2s_clk;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    ahbl_i2s_rx_fifo #(.SAMPLE_W(W), .FIFO_DEPTH(16), .CLKDIV_RST(7)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HWDATA(HWDATA), .HSEL(HSEL), .HREADY(HREADY), .HRDATA(HRDATA),
        .HREADYOUT(HREADYOUT), .rx(rx), .ws(ws), .i2s_clk(i2s_clk), .irq(irq)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // I2S slave transmitter: bit k of a slot goes out on the k+1-th SCK fall
    // after the WS change, the LSB coinciding with the next WS change.
    logic [W-1:0] left_q[$];
    logic [W-1:0] right_q[$];
    logic [W-1:0] cur_word;
    int           bidx;
    logic         need_load;
    logic         prev_ws;

    task automatic bfm_reset();
        left_q.delete();
        right_q.delete();
        cur_word  = '0;
        bidx      = 0;
        need_load = 1'b1;
        prev_ws   = 1'b0;
        rx        = 1'b0;
    endtask

    always @(negedge i2s_clk) begin
        #1;
        if (need_load) begin
            cur_word = '0;
            if (!ws && left_q.size() > 0)
                cur_word = left_q.pop_front();
            else if (ws && right_q.size() > 0)
                cur_word = right_q.pop_front();
            bidx      = 0;
            need_load = 1'b0;
        end
        rx = (bidx < W) ? cur_word[W-1-bidx] : 1'b0;
        bidx++;
        if (ws != prev_ws) begin
            need_load = 1'b1;
            prev_ws   = ws;
        end
    end

    task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge HCLK);
        HADDR = addr; HTRANS = 2'b10; HWRITE = 1'b1; HSEL = 1'b1;
        @(negedge HCLK);
        HTRANS = 2'b00; HSEL = 1'b0; HWRITE = 1'b0; HWDATA = data;
    endtask

    task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge HCLK);
        HADDR = addr; HTRANS = 2'b10; HWRITE = 1'b0; HSEL = 1'b1;
        @(negedge HCLK);
        HTRANS = 2'b00; HSEL = 1'b0;
        data = HRDATA;
    endtask

    task automatic wait_level(input int n, input int budget);
        logic [31:0] st;
        int          i;
        st = '0;
        for (i = 0; i < budget; i++) begin
            ahb_read(A_STATUS, st);
            if (int'(st[20:16]) >= n)
                break;
        end
        n_vec++;
        if (i >= budget) begin
            n_err++;
            $display("FAIL wait_level_%0d: level stuck at %0d, required %0d", n, st[20:16], n);
        end
    endtask

    function automatic logic [31:0] sext(input logic [W-1:0] v);
        return {{(32-W){v[W-1]}}, v};
    endfunction

    function automatic logic [W-1:0] pat(input int j);
        logic [31:0] t;
        t = (j * 32'h0001_3579) ^ 32'h00A5_C35A;
        return t[W-1:0];
    endfunction

    task automatic test_reset();
        logic [31:0] r;
        HRESET = 1'b1;
        repeat (3) @(negedge HCLK);
        HRESET = 1'b0;
        @(negedge HCLK);
        n_vec++; if ({ws, i2s_clk, irq} !== 3'b000) begin n_err++; $display("FAIL reset_outputs got=%b exp=000", {ws, i2s_clk, irq}); end
        n_vec++; if (HRDATA !== 32'h0) begin n_err++; $display("FAIL reset_hrdata got=%h exp=%h", HRDATA, 32'h0); end
        n_vec++; if (HREADYOUT !== 1'b1) begin n_err++; $display("FAIL reset_hreadyout got=%b exp=1", HREADYOUT); end
        ahb_read(A_STATUS, r);
        n_vec++; if (r !== 32'h1) begin n_err++; $display("FAIL reset_status got=%h exp=%h", r, 32'h1); end
        ahb_read(A_CLKDIV, r);
        n_vec++; if (r !== 32'h7) begin n_err++; $display("FAIL reset_clkdiv got=%h exp=%h", r, 32'h7); end
        ahb_read(A_CTRL, r);
        n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL reset_ctrl got=%h exp=%h", r, 32'h0); end
        ahb_read(A_DATA, r);
        n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL reset_data_empty got=%h exp=%h", r, 32'h0); end
        ahb_read(32'h40, r);
        n_vec++; if (r !== 32'hDEADBEEF) begin n_err++; $display("FAIL reset_unmapped got=%h exp=%h", r, 32'hDEADBEEF); end
    endtask

    task automatic test_stereo();
        logic [31:0] r;
        logic        prev;
        int          first_rise, second_rise;
        ahb_write(A_CLKDIV, 32'h1);
        ahb_read(A_CLKDIV, r);
        n_vec++; if (r !== 32'h1) begin n_err++; $display("FAIL stereo_clkdiv_rb got=%h exp=%h", r, 32'h1); end
        bfm_reset();
        left_q.push_back(24'h123456);
        right_q.push_back(24'hABCDEF);
        ahb_write(A_CTRL, 32'h5);
        first_rise = -1; second_rise = -1; prev = i2s_clk;
        for (int c = 0; c < 100 && second_rise < 0; c++) begin
            @(negedge HCLK);
            if (i2s_clk && !prev) begin
                if (first_rise < 0) first_rise = c;
                else second_rise = c;
            end
            prev = i2s_clk;
        end
        n_vec++; if (second_rise - first_rise != 4) begin n_err++; $display("FAIL stereo_sck_period got=%0d exp=4", second_rise - first_rise); end
        wait_level(2, 400);
        ahb_write(A_CTRL, 32'h4);
        ahb_read(A_DATA, r);
        n_vec++; if (r !== 32'h00123456) begin n_err++; $display("FAIL stereo_left got=%h exp=%h", r, 32'h00123456); end
        ahb_read(A_DATA, r);
        n_vec++; if (r !== 32'hFFABCDEF) begin n_err++; $display("FAIL stereo_right got=%h exp=%h", r, 32'hFFABCDEF); end
        ahb_read(A_STATUS, r);
        n_vec++; if (r !== 32'h1) begin n_err++; $display("FAIL stereo_empty got=%h exp=%h", r, 32'h1); end
    endtask

    task automatic test_right_only();
        logic [31:0] r;
        logic [W-1:0] rv [4];
        rv[0] = 24'h800001; rv[1] = 24'h7FFFFF; rv[2] = 24'h00A5A5; rv[3] = 24'hC0FFEE;
        ahb_write(A_CTRL, 32'h8);
        repeat (3) @(negedge HCLK);
        bfm_reset();
        for (int i = 0; i < 4; i++) begin
            left_q.push_back(24'h111111 * (i + 1));
            right_q.push_back(rv[i]);
        end
        ahb_write(A_CTRL, 32'h3);
        wait_level(4, 1500);
        ahb_write(A_CTRL, 32'h2);
        ahb_read(A_STATUS, r);
        n_vec++; if (r !== 32'h00040000) begin n_err++; $display("FAIL right_status got=%h exp=%h", r, 32'h00040000); end
        for (int i = 0; i < 4; i++) begin
            ahb_read(A_DATA, r);
            n_vec++; if (r !== sext(rv[i])) begin n_err++; $display("FAIL right_pop%0d got=%h exp=%h", i, r, sext(rv[i])); end
        end
    endtask

    task automatic test_threshold();
        logic [31:0] r;
        ahb_write(A_CTRL, 32'h8);
        repeat (3) @(negedge HCLK);
        bfm_reset();
        for (int i = 0; i < 6; i++) begin
            left_q.push_back(24'h000100 + 24'(i));
            right_q.push_back(24'h000200 + 24'(i));
        end
        ahb_write(A_CTRL, 32'h805);
        ahb_read(A_CTRL, r);
        n_vec++; if (r !== 32'h805) begin n_err++; $display("FAIL thresh_ctrl_rb got=%h exp=%h", r, 32'h805); end
        wait_level(7, 1500);
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL thresh_irq_at7 got=%b exp=0", irq); end
        wait_level(8, 200);
        repeat (2) @(negedge HCLK);
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL thresh_irq_at8 got=%b exp=1", irq); end
        ahb_write(A_CTRL, 32'h804);
        ahb_read(A_STATUS, r);
        n_vec++; if (r !== 32'h00080000) begin n_err++; $display("FAIL thresh_status8 got=%h exp=%h", r, 32'h00080000); end
        ahb_read(A_DATA, r);
        n_vec++; if (r !== 32'h00000100) begin n_err++; $display("FAIL thresh_pop got=%h exp=%h", r, 32'h00000100); end
        repeat (2) @(negedge HCLK);
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL thresh_irq_at7_after_pop got=%b exp=0", irq); end
        ahb_read(A_STATUS, r);
        n_vec++; if (r !== 32'h00070000) begin n_err++; $display("FAIL thresh_status7 got=%h exp=%h", r, 32'h00070000); end
    endtask

    task automatic test_overflow();
        logic [31:0] r;
        int          i;
        ahb_write(A_CTRL, 32'h8);
        repeat (3) @(negedge HCLK);
        bfm_reset();
        for (int k = 0; k < 12; k++) begin
            left_q.push_back(pat(2 * k));
            right_q.push_back(pat(2 * k + 1));
        end
        ahb_write(A_CTRL, 32'h5);
        r = '0;
        for (i = 0; i < 2000; i++) begin
            ahb_read(A_STATUS, r);
            if (r[2]) break;
        end
        n_vec++; if (i >= 2000) begin n_err++; $display("FAIL ovf_wait: status stuck at %h, required OVF set", r); end
        repeat (240) @(negedge HCLK);
        ahb_write(A_CTRL, 32'h4);
        ahb_read(A_STATUS, r);
        n_vec++; if (r !== 32'h00100006) begin n_err++; $display("FAIL ovf_status got=%h exp=%h", r, 32'h00100006); end
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL ovf_irq got=%b exp=1", irq); end
        for (int j = 0; j < 16; j++) begin
            ahb_read(A_DATA, r);
            n_vec++; if (r !== sext(pat(j))) begin n_err++; $display("FAIL ovf_pop%0d got=%h exp=%h", j, r, sext(pat(j))); end
        end
        ahb_read(A_STATUS, r);
        n_vec++; if (r !== 32'h5) begin n_err++; $display("FAIL ovf_drained got=%h exp=%h", r, 32'h5); end
        ahb_write(A_CTRL, 32'h8);
        repeat (2) @(negedge HCLK);
        ahb_read(A_STATUS, r);
        n_vec++; if (r !== 32'h1) begin n_err++; $display("FAIL clr_status got=%h exp=%h", r, 32'h1); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL clr_irq got=%b exp=0", irq); end
    endtask

    task automatic test_abort();
        logic [31:0] r;
        ahb_write(A_CTRL, 32'h8);
        repeat (3) @(negedge HCLK);
        bfm_reset();
        left_q.push_back(24'h7AAAAA);
        right_q.push_back(24'h155555);
        ahb_write(A_CTRL, 32'h5);
        repeat (60) @(negedge HCLK);
        ahb_write(A_CTRL, 32'h4);
        repeat (2) @(negedge HCLK);
        for (int k = 0; k < 4; k++) begin
            repeat (7) @(negedge HCLK);
            n_vec++; if ({ws, i2s_clk} !== 2'b00) begin n_err++; $display("FAIL abort_idle%0d got=%b exp=00", k, {ws, i2s_clk}); end
        end
        ahb_read(A_STATUS, r);
        n_vec++; if (r !== 32'h1) begin n_err++; $display("FAIL abort_no_partial got=%h exp=%h", r, 32'h1); end
        bfm_reset();
        left_q.push_back(24'h654321);
        right_q.push_back(24'h89ABCD);
        ahb_write(A_CTRL, 32'h5);
        wait_level(2, 400);
        ahb_write(A_CTRL, 32'h4);
        ahb_read(A_DATA, r);
        n_vec++; if (r !== 32'h00654321) begin n_err++; $display("FAIL abort_left got=%h exp=%h", r, 32'h00654321); end
        ahb_read(A_DATA, r);
        n_vec++; if (r !== 32'hFF89ABCD) begin n_err++; $display("FAIL abort_right got=%h exp=%h", r, 32'hFF89ABCD); end
    endtask

    initial begin
        bfm_reset();
        test_reset();
        test_stereo();
        test_right_only();
        test_threshold();
        test_overflow();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
